// File: rtl/led_spi_pkg.sv
// -----------------------------------------------------------------------------
// led_spi_pkg
// Shared definitions for the SPI LED target:
//   WORD_W_DEF      - default bits per LED word (one bit per matrix LED)
//   SYNC_STAGES_DEF - default synchronizer depth on each SPI input
//   state_t         - target FSM encoding (IDLE = CS high, SHIFT = CS low)
//   SPI_CS/SCK/SI   - indices of the SPI inputs in the packed sync vectors
// -----------------------------------------------------------------------------
package led_spi_pkg;

    localparam int WORD_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    // Index of each SPI input inside the packed synchronizer bundle.
    localparam int SPI_CS   = 0;
    localparam int SPI_SCK  = 1;
    localparam int SPI_SI   = 2;
    localparam int SPI_NSIG = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through STAGES flops,
// then compares the synchronized level with a one-clk-delayed copy to flag
// edges.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset, clears every flop to 0
//   din   - asynchronous input pin
//   level - synchronized level
//   rise  - one-clk pulse on a synchronized 0->1 transition
//   fall  - one-clk pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  =  sync_reg[STAGES-1] & ~prev_reg;
    assign fall  = ~sync_reg[STAGES-1] &  prev_reg;

endmodule

// File: rtl/spi_led_target.sv
// -----------------------------------------------------------------------------
// spi_led_target
// SPI mode-0 target that receives LED words (MSB first) from the host and
// presents the last complete word to the LED matrix scanner. The SPI pins are
// oversampled in the clk domain; nothing is clocked by cfg_sck. While a frame
// is open the previous word is shifted back out on cfg_so.
// Ports:
//   clk        - system clock (48 MHz)
//   rst_n      - synchronous active-low reset
//   cfg_cs     - SPI chip select, active-low, asynchronous
//   cfg_sck    - SPI clock, CPOL=0 CPHA=0, asynchronous
//   cfg_si     - SPI MOSI, MSB first
//   cfg_so     - SPI MISO, MSB first, 0 when no frame is open
//   ledbits    - last completed word
//   word_valid - one-clk pulse when ledbits updates
//   frame_err  - one-clk pulse when CS rises with a partial word pending
//   busy       - high while a frame is open
// -----------------------------------------------------------------------------
module spi_led_target
    import led_spi_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cs,
    input  logic              cfg_sck,
    input  logic              cfg_si,
    output logic              cfg_so,
    output logic [WORD_W-1:0] ledbits,
    output logic              word_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    // ---------------------------------------------------------------------
    // Input synchronizers, one per SPI pin
    // ---------------------------------------------------------------------
    logic [SPI_NSIG-1:0] pin_raw;
    logic [SPI_NSIG-1:0] pin_level;
    logic [SPI_NSIG-1:0] pin_rise;
    logic [SPI_NSIG-1:0] pin_fall;

    assign pin_raw[SPI_CS]  = cfg_cs;
    assign pin_raw[SPI_SCK] = cfg_sck;
    assign pin_raw[SPI_SI]  = cfg_si;

    genvar gi;
    generate
        for (gi = 0; gi < SPI_NSIG; gi++) begin : g_sync
            spi_sync_edge #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (pin_raw[gi]),
                .level (pin_level[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic sck_fall;
    logic si_level;

    assign cs_fall  = pin_fall[SPI_CS];
    assign cs_rise  = pin_rise[SPI_CS];
    assign sck_rise = pin_rise[SPI_SCK];
    assign sck_fall = pin_fall[SPI_SCK];
    assign si_level = pin_level[SPI_SI];

    // Only edges matter for CS/SCK and only the level for SI.
    logic unused_sync;
    assign unused_sync = ^{pin_level[SPI_CS], pin_level[SPI_SCK],
                           pin_rise[SPI_SI], pin_fall[SPI_SI]};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t              state_reg,  state_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic [WORD_W-1:0]   rx_reg,     rx_next;
    logic [WORD_W-1:0]   shadow_reg, shadow_next;
    logic [WORD_W-1:0]   led_reg,    led_next;
    logic                wv_reg,     wv_next;
    logic                fe_reg,     fe_next;
    logic [WORD_W-1:0]   rx_shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rx_reg     <= '0;
            shadow_reg <= '0;
            led_reg    <= '0;
            wv_reg     <= 1'b0;
            fe_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rx_reg     <= rx_next;
            shadow_reg <= shadow_next;
            led_reg    <= led_next;
            wv_reg     <= wv_next;
            fe_reg     <= fe_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rx_next     = rx_reg;
        shadow_next = shadow_reg;
        led_next    = led_reg;
        wv_next     = 1'b0;
        fe_next     = 1'b0;
        rx_shifted  = {rx_reg[WORD_W-2:0], si_level};

        case (state_reg)
            IDLE: begin
                // SCK activity and a stray CS rise are ignored here.
                if (cs_fall) begin
                    state_next  = SHIFT;
                    cnt_next    = '0;
                    rx_next     = '0;
                    shadow_next = led_reg;
                end
            end

            SHIFT: begin
                // CS edges take priority over any SCK edge in the same clk.
                if (cs_rise) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (cnt_reg != '0) begin
                        fe_next = 1'b1;
                    end
                end else if (sck_rise) begin
                    rx_next = rx_shifted;
                    if (cnt_reg == LAST_BIT) begin
                        led_next    = rx_shifted;
                        shadow_next = rx_shifted;
                        wv_next     = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else if (sck_fall && (cnt_reg != '0)) begin
                    // With SCK idling low, a fall at count 0 can only be the
                    // trailing edge of a just-completed word; the shadow was
                    // reloaded on that word's last rise and its MSB must stay
                    // on MISO for the host's next sample.
                    shadow_next = {shadow_reg[WORD_W-2:0], 1'b0};
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ledbits    = led_reg;
    assign word_valid = wv_reg;
    assign frame_err  = fe_reg;
    assign busy       = (state_reg == SHIFT);
    assign cfg_so     = (state_reg == SHIFT) & shadow_reg[WORD_W-1];

endmodule

// File: doc/spi_led_target.md
SPI_LED_TARGET -- requirements
Module: spi_led_target

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning bits per LED word (one bit per matrix LED).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on each SPI input.
REQ-003 SHALL have port clk, input, 1, system clock (48 MHz internal oscillator).
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous to clk, active-low.
REQ-005 SHALL have port cfg_cs, input, 1, SPI chip select from the samd51, active-low, asynchronous to clk.
REQ-006 SHALL have port cfg_sck, input, 1, SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 SHALL have port cfg_si, input, 1, SPI data in (MOSI), MSB first.
REQ-008 SHALL have port cfg_so, output, 1, SPI data out (MISO), MSB first.
REQ-009 SHALL have port ledbits, output, WORD_W, last completed word, for the LED matrix scanner.
REQ-010 SHALL have port word_valid, output, 1, one-clk pulse when ledbits updates.
REQ-011 SHALL have port frame_err, output, 1, one-clk pulse when CS deasserts mid-word.
REQ-012 SHALL have port busy, output, 1, high while synchronized CS is low.

Function
REQ-013 SHALL pass cfg_cs, cfg_sck and cfg_si through SYNC_STAGES flip-flops before use; no logic SHALL be clocked by cfg_sck.
REQ-014 SHALL detect SCK rise/fall, and CS fall/rise, by comparing the synchronized value with its one-clk-delayed copy.
REQ-015 SHALL support fSCK <= fclk/6 (8 MHz at 48 MHz); behaviour above this is undefined.
REQ-016 SHALL use states IDLE (CS high) and SHIFT (CS low); CS fall: IDLE->SHIFT; CS rise: SHIFT->IDLE.
REQ-017 On CS fall SHALL clear the bit counter to 0 and load the MISO shadow register with the current ledbits.
REQ-018 In SHIFT, on each SCK rise SHALL shift synchronized cfg_si into the LSB of the receive register and increment the bit counter.
REQ-019 When the bit counter reaches WORD_W, SHALL copy the receive register to ledbits, pulse word_valid in the next clk, and wrap the counter to 0.
REQ-020 SHALL accept any number of consecutive words in one CS frame; each completed word updates ledbits.
REQ-021 In SHIFT, on each SCK fall SHALL shift the MISO shadow left by one; cfg_so SHALL equal shadow MSB while in SHIFT.
REQ-022 After each completed word, SHALL reload the shadow with the newly latched ledbits, so the host reads back the previous word.
REQ-023 cfg_so SHALL be 0 in IDLE.
REQ-024 On CS rise with bit counter not 0, SHALL discard the partial word, leave ledbits unchanged and pulse frame_err once.
REQ-025 On CS rise with bit counter 0, SHALL NOT pulse frame_err.
REQ-026 If a CS edge and an SCK edge are detected in the same clk, the CS edge SHALL win and the SCK edge SHALL be ignored.
REQ-027 SCK edges in IDLE SHALL be ignored.
REQ-028 word_valid and frame_err SHALL never be high in the same clk.

Reset
REQ-029 When rst_n is low at a clk edge, SHALL go to IDLE and clear ledbits, word_valid, frame_err, busy, cfg_so, the counter, the shift registers and the synchronizers, all to 0.
REQ-030 Reset asserted mid-frame SHALL abort the word without a frame_err pulse; after release with CS still low, the block SHALL stay in IDLE until a new CS fall.

Structure
REQ-031 WORD_W default, SYNC_STAGES default and the state encoding (IDLE=0, SHIFT=1) SHALL live in shared package led_spi_pkg.
REQ-032 The synchronizer and edge detector SHALL be one sub-module, spi_sync_edge, instantiated once per SPI input; it outputs level, rise and fall.

Verification
REQ-033 Reset, then CS low, send 0xA5C3 at 4 MHz, CS high -> ledbits=0xA5C3, one word_valid pulse, no frame_err, cfg_so returns 0x0000.
REQ-034 Two words 0x0001 then 0x8000 in one CS frame -> two word_valid pulses, final ledbits=0x8000, MISO during second word = 0x0001.
REQ-035 CS low, 9 SCK cycles, CS high -> ledbits unchanged, exactly one frame_err pulse, no word_valid.
REQ-036 SCK toggling while CS high -> no state change, cfg_so=0, busy=0.
REQ-037 rst_n low after 10 bits of a frame, released with CS still low, then remaining 6 bits -> ledbits=0, no word_valid, no frame_err; the next full frame 0x1234 gives ledbits=0x1234.
REQ-038 Frame at 8 MHz SCK (fclk/6) with random data over 1000 words -> every ledbits equals the sent word; readback equals the previous word.
